// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
// Multi-channel clock-enable divider for the system clock domain.
// A shared base prescaler produces the fast square wave (fast_clk). Each of the
// NCH slow channels divides fast_clk by 2^sel, where sel can be changed at run
// time. A new sel is captured on a rising edge of `update`. It takes effect at
// the next falling edge of that channel's slow_clk, which prevents runt pulses.
//
// Optional build macro:
//   CLK_DIV_BANK_SYNC_IN_EN - routes update/ch_idx/prog_in through a two-flop
//                             synchronizer for asynchronous sources. This adds
//                             two cycles of detection latency.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module clk_div_bank #(
   parameter int BASE_DIV = 5000000,
   parameter int NCH      = 2,
   parameter int CH_W     = 1,
   parameter int SEL_W    = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   update,
   input  logic [CH_W-1:0]        ch_idx,
   input  logic [SEL_W-1:0]       prog_in,
   output logic                   fast_clk,
   output logic [NCH-1:0]         slow_clk,
   output logic [NCH-1:0]         slow_tick,
   output logic [NCH*SEL_W-1:0]   prog_out,
   output logic [NCH-1:0]         busy
);

   // Base counter width, and half-period counter width (2^SEL_W-1 bits holds 2^sel-1 at max sel)
   localparam int              BW        = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
   localparam int              CW        = (1 << SEL_W) - 1;
   localparam logic [BW-1:0]   BASE_LAST = BW'(BASE_DIV - 1);

   // Terminal count of a half period: 2^sel - 1 base ticks
   function automatic logic [CW-1:0] half_lim(input logic [SEL_W-1:0] sel);
      logic [CW-1:0] ones;
      ones = {CW{1'b1}};
      return ones >> (CW - int'(sel));
   endfunction

   // ------------------------------------------------------------------
   // Input stage
   // ------------------------------------------------------------------
   logic                update_in_s;
   logic [CH_W-1:0]     ch_idx_in_s;
   logic [SEL_W-1:0]    prog_in_in_s;

`ifdef CLK_DIV_BANK_SYNC_IN_EN
   logic                update_m_q,  update_m_d,  update_s_q,  update_s_d;
   logic [CH_W-1:0]     ch_idx_m_q,  ch_idx_m_d,  ch_idx_s_q,  ch_idx_s_d;
   logic [SEL_W-1:0]    prog_in_m_q, prog_in_m_d, prog_in_s_q, prog_in_s_d;

   // Two-stage synchronizer: first stage samples the raw inputs, second stage re-samples
   always_comb begin
      update_m_d  = update;
      ch_idx_m_d  = ch_idx;
      prog_in_m_d = prog_in;
      update_s_d  = update_m_q;
      ch_idx_s_d  = ch_idx_m_q;
      prog_in_s_d = prog_in_m_q;
   end

   // Synchronizer flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         update_m_q  <= 1'b0;
         ch_idx_m_q  <= '0;
         prog_in_m_q <= '0;
         update_s_q  <= 1'b0;
         ch_idx_s_q  <= '0;
         prog_in_s_q <= '0;
      end else begin
         update_m_q  <= update_m_d;
         ch_idx_m_q  <= ch_idx_m_d;
         prog_in_m_q <= prog_in_m_d;
         update_s_q  <= update_s_d;
         ch_idx_s_q  <= ch_idx_s_d;
         prog_in_s_q <= prog_in_s_d;
      end
   end

   assign update_in_s  = update_s_q;
   assign ch_idx_in_s  = ch_idx_s_q;
   assign prog_in_in_s = prog_in_s_q;
`else
   assign update_in_s  = update;
   assign ch_idx_in_s  = ch_idx;
   assign prog_in_in_s = prog_in;
`endif

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [BW-1:0]        base_cnt_q, base_cnt_d;
   logic                 base_tick_s;
   logic                 fast_clk_q, fast_clk_d;
   logic                 upd_prev_q, upd_prev_d;
   logic                 upd_rise_s;
   logic [NCH-1:0]       slow_clk_q,  slow_clk_d;
   logic [NCH-1:0]       slow_tick_q, slow_tick_d;
   logic [NCH-1:0]       busy_q,      busy_d;
   logic [NCH-1:0]       toggle_s, cap_s, apply_s;
   logic [NCH*SEL_W-1:0] sel_q,  sel_d;
   logic [NCH*SEL_W-1:0] pend_q, pend_d;
   logic [CW-1:0]        cnt_q [NCH];
   logic [CW-1:0]        cnt_d [NCH];

   // Base prescaler: wrap at BASE_DIV-1, flip fast_clk on every wrap
   always_comb begin
      base_tick_s = (base_cnt_q == BASE_LAST);
      if (base_tick_s) begin
         base_cnt_d = '0;
      end else begin
         base_cnt_d = base_cnt_q + 1'b1;
      end
      fast_clk_d = fast_clk_q ^ base_tick_s;
   end

   // Update request edge detection against the registered copy of update
   always_comb begin
      upd_prev_d = update_in_s;
      upd_rise_s = update_in_s & ~upd_prev_q;
   end

   // Per-channel events: half-period toggle, request capture, and apply at the 1->0 toggle
   always_comb begin
      toggle_s = '0;
      cap_s    = '0;
      apply_s  = '0;
      for (int i = 0; i < NCH; i++) begin
         toggle_s[i] = base_tick_s && (cnt_q[i] == half_lim(sel_q[i*SEL_W +: SEL_W]));
         // Out-of-range indices never match a channel, so they are dropped silently
         cap_s[i]    = upd_rise_s && (ch_idx_in_s == CH_W'(i));
         apply_s[i]  = toggle_s[i] && slow_clk_q[i] && busy_q[i];
      end
   end

   // Per-channel next state; a capture on the apply edge stays pending for the next boundary
   always_comb begin
      slow_clk_d  = slow_clk_q;
      slow_tick_d = '0;
      busy_d      = busy_q;
      sel_d       = sel_q;
      pend_d      = pend_q;
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (toggle_s[i]) begin
            cnt_d[i] = '0;
         end else if (base_tick_s) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end else begin
            cnt_d[i] = cnt_q[i];
         end

         slow_clk_d[i]  = slow_clk_q[i] ^ toggle_s[i];
         slow_tick_d[i] = toggle_s[i] & ~slow_clk_q[i];

         if (apply_s[i]) begin
            sel_d[i*SEL_W +: SEL_W] = pend_q[i*SEL_W +: SEL_W];
         end else begin
            sel_d[i*SEL_W +: SEL_W] = sel_q[i*SEL_W +: SEL_W];
         end

         if (cap_s[i]) begin
            pend_d[i*SEL_W +: SEL_W] = prog_in_in_s;
         end else begin
            pend_d[i*SEL_W +: SEL_W] = pend_q[i*SEL_W +: SEL_W];
         end

         if (cap_s[i]) begin
            busy_d[i] = 1'b1;
         end else if (apply_s[i]) begin
            busy_d[i] = 1'b0;
         end else begin
            busy_d[i] = busy_q[i];
         end
      end
   end

   // State flops; reset discards pending updates and realigns every channel to fast_clk
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_cnt_q  <= '0;
         fast_clk_q  <= 1'b0;
         upd_prev_q  <= 1'b0;
         slow_clk_q  <= '0;
         slow_tick_q <= '0;
         busy_q      <= '0;
         sel_q       <= '0;
         pend_q      <= '0;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         base_cnt_q  <= base_cnt_d;
         fast_clk_q  <= fast_clk_d;
         upd_prev_q  <= upd_prev_d;
         slow_clk_q  <= slow_clk_d;
         slow_tick_q <= slow_tick_d;
         busy_q      <= busy_d;
         sel_q       <= sel_d;
         pend_q      <= pend_d;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign fast_clk  = fast_clk_q;
   assign slow_clk  = slow_clk_q;
   assign slow_tick = slow_tick_q;
   assign prog_out  = sel_q;
   assign busy      = busy_q;

endmodule
